// File: rtl/noc_pkg.sv
// Shared packet layout and direction encoding for the NoC router output stage.
package noc_pkg;

  localparam int WIDTH    = 39;
  localparam int TYPE_MSB = 38;
  localparam int X_MSB    = 36;
  localparam int X_LSB    = 33;
  localparam int Y_MSB    = 32;
  localparam int Y_LSB    = 29;

  typedef struct packed {
    logic [1:0]  ptype;
    logic [3:0]  x;
    logic [3:0]  y;
    logic [28:0] payload;
  } packet_t;

  typedef enum logic [2:0] {
    DIR_LOCAL,
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

endpackage

// File: rtl/noc_output_merge_rr_arb4.sv
// Four-way round-robin arbiter; search starts at rr_q, pointer moves past the winner on adv.
module rr_arb4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       en,
  input  logic       adv,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);
  logic [1:0] rr_q;
  logic [1:0] j;
  logic       found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = rr_q;
    j       = '0;
    for (int k = 0; k < 4; k++) begin
      j = rr_q + 2'(k);
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt_idx = j;
      end
    end
    gnt = (found && en) ? (4'b0001 << gnt_idx) : 4'b0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rr_q <= '0;
    else if (adv) rr_q <= gnt_idx + 2'd1;
  end

endmodule

// File: rtl/noc_output_merge.sv
// Output-port merge: round-robin over four switch streams into a small FIFO, tagging the source.
// Optional per-input grant counters on stat_grants when NOC_MERGE_STATS_EN is defined.
module noc_output_merge #(
  parameter int WIDTH = noc_pkg::WIDTH,
  parameter int DEPTH = 2,
  parameter int NIN   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NIN-1:0]     in_valid,
  input  logic [NIN*WIDTH-1:0] in_data,
  output logic [NIN-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_src,
  input  logic               out_ready
`ifdef NOC_MERGE_STATS_EN
  ,
  output logic [NIN*16-1:0]  stat_grants
`endif
);
  import noc_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [NIN-1:0][WIDTH-1:0] in_arr;
  logic [DEPTH-1:0][WIDTH+1:0] mem_q;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [NIN-1:0] gnt;
  logic [1:0]    gnt_idx;
  logic          space, push, pop;

  assign in_arr = in_data;
  // Space comes from the registered count only, so a same-cycle pop never frees a slot.
  assign space  = count_q < (AW+1)'(DEPTH);

  rr_arb4 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .en      (space & ~rst),
    .adv     (push),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign in_ready  = gnt;
  assign push      = |(in_valid & gnt);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  assign {out_src, out_data} = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      mem_q    <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {gnt_idx, in_arr[gnt_idx]};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

`ifdef NOC_MERGE_STATS_EN
  for (genvar i = 0; i < NIN; i++) begin : g_stat
    logic [15:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    cnt_q <= '0;
      else if (push && gnt[i] && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
    assign stat_grants[i*16 +: 16] = cnt_q;
  end
`endif

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(in_ready));
  a_count:  assert property (@(posedge clk) disable iff (rst) count_q <= (AW+1)'(DEPTH));
  for (genvar i = 0; i < NIN; i++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (rst)
      (in_valid[i] && !in_ready[i]) |=> (!in_valid[i] || $stable(in_data[i*WIDTH +: WIDTH])));
  end

endmodule

// File: doc/noc_output_merge.md
Name: noc_output_merge

Overview:
- Clocked output-port stage of a mesh router; sits directly downstream of the per-input direction switches.
- The switches for the other four input directions each steer packets toward one output direction. This block merges those four streams into one output link.
- Merging uses fair round-robin arbitration and a small output FIFO. The block also forwards the 2-bit source index with each packet.

Parameters:
- WIDTH, 39, packet width. Fields: [38:37] type, [36:33] dest x, [32:29] dest y, [28:0] payload.
- DEPTH, 2, output FIFO entries (power of two, >=2).
- NIN, 4, number of merged inputs (fixed at 4; the parameter exists only for documentation and checks).

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  4  per-input packet valid, bit i = input i.
- in_data  input  4*WIDTH  input i occupies [i*WIDTH +: WIDTH].
- in_ready  output  4  one-hot or zero; high = input i accepted this cycle.
- out_valid  output  1  FIFO head valid.
- out_data  output  WIDTH  FIFO head packet.
- out_src  output  2  input index that supplied the head packet.
- out_ready  input  1  downstream accepts the head when high together with out_valid.
- stat_grants  output  4*16  per-input grant counters (present only with NOC_MERGE_STATS_EN).

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- State cleared on rst assertion, immediately and without waiting for clk: count=0, rd_ptr=0, wr_ptr=0, rr_ptr=0, out_valid=0, out_data=0, out_src=0, in_ready=0, stat_grants=0.
- Reset mid-operation discards all buffered packets. No partial transfer completes on the edge coincident with rst.
- space = (count < DEPTH), taken from the registered count. A pop in the same cycle does not free a slot for a same-cycle push.
  - Consequence: at count==DEPTH with out_ready=1, in_ready=0 that cycle.
- Arbitration is combinational from in_valid, rr_ptr and space. Search order is rr_ptr, rr_ptr+1, ... mod 4. The first valid input wins.
  - in_ready[g] = 1 for the winner only, and only when space=1.
  - All in_ready = 0 when no input is valid or space=0.
- Push happens on an edge where in_valid[g] & in_ready[g]:
  - FIFO[wr_ptr] <= {g, in_data[g]}.
  - wr_ptr increments mod DEPTH.
  - rr_ptr <= (g+1) mod 4.
- rr_ptr holds when there is no push. Losing inputs keep in_valid high and must hold their data stable; no data is dropped.
- Pop happens on an edge where out_valid & out_ready: rd_ptr increments mod DEPTH.
- out_valid = (count != 0). out_data and out_src = FIFO[rd_ptr].
- count update per edge:
  - push only: +1.
  - pop only: -1.
  - push and pop together (possible only when 0<count<DEPTH): unchanged.
- Latency: a packet accepted at edge N is visible at the output in the cycle after edge N, giving a minimum 1-cycle input-to-output latency. Throughput is 1 packet/cycle while count<DEPTH is sustained.
- Boundaries:
  - Empty: out_valid=0 and out_ready is ignored.
  - Full: no push.
  - Pointer wrap: the DEPTH-1 -> 0 transition is exercised every DEPTH transfers.
  - rr_ptr wrap: 3 -> 0.
- The packet is not modified; routing fields pass through unchanged.
- Assertions (simulation only):
  - in_ready is onehot0.
  - in_data[i] is stable while in_valid[i] & !in_ready[i].
  - count <= DEPTH.

Optional Feature:
- NOC_MERGE_STATS_EN defined:
  - The stat_grants port exists.
  - Counter i increments on each push from input i and saturates at 16'hFFFF.
  - Counters are cleared by rst.
- Not defined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Package noc_pkg:
  - WIDTH = 39.
  - Field localparams: TYPE_MSB=38, X_MSB=36, X_LSB=33, Y_MSB=32, Y_LSB=29.
  - packet_t packed struct {type, x, y, payload}.
  - dir_e enum {DIR_LOCAL, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT}.
- Sub-module rr_arb4:
  - Inputs: req[3:0], en.
  - Outputs: gnt[3:0] one-hot, gnt_idx[1:0].
  - Owns the rr_ptr register, updated when the parent asserts an advance signal.
- The FIFO stays inline in noc_output_merge.

Test Plan:
- Reset mid-stream: count=2, assert rst between edges -> out_valid=0 and in_ready=0 immediately; after release, the first packet accepted is a new one.
- Single input: in_valid=4'b0100, data 0x0_2222_0001, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=0x0_2222_0001, out_src=2.
- Fairness: all four inputs valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1... with rr_ptr starting at 0; each input gets exactly 25 of 100 grants.
- Full backpressure: out_ready=0, two pushes -> count=2 and in_ready=0. Then raise out_ready for one cycle -> that cycle has a pop with no push; the following cycle accepts the next input.
- Wrap/ordering: 10 packets tagged 1..10 from mixed inputs with random out_ready -> output order equals grant order, and out_src matches the supplying input for each packet.
- Stats (macro on): 70000 grants to input 1 -> stat_grants[16 +: 16]=16'hFFFF; the other counters hold their exact grant counts.
